// File: rtl/uart_bus_responder.sv
// Memory-stage responder for the on-board UART (data 0xBF00, status 0xBF01).
// Optional wait-state timeout: define UART_BUS_RESPONDER_TIMEOUT_EN.
module uart_bus_responder #(
  parameter int unsigned WR_PULSE_CYC = 2,
  parameter int unsigned RD_PULSE_CYC = 2,
  parameter int unsigned TIMEOUT_CYC  = 4096
) (
  input  logic        uci_clk,
  input  logic        uci_rst,
  input  logic        uci_req,
  input  logic        uci_we,
  input  logic        uci_sel,
  input  logic [7:0]  uci_wdata,
  output logic        uco_ack,
  output logic [15:0] uco_rdata,
  output logic        uco_stall,
  output logic        uco_err,
  output logic        uco_bus_own,
  output logic        uco_data_oe,
  output logic [7:0]  uco_data_out,
  input  logic [7:0]  uci_data_in,
  output logic        uco_wrn,
  output logic        uco_rdn,
  input  logic        uci_tbre,
  input  logic        uci_tsre,
  input  logic        uci_data_ready
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned WAIT_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RDATA_W = 16;

  // Pulse counters are 8 bits wide and the wait counter 16 bits wide.
  if (WR_PULSE_CYC < 1 || WR_PULSE_CYC > 255 || RD_PULSE_CYC < 1 || RD_PULSE_CYC > 255 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
    $error("uart_bus_responder: parameter out of range");
  end

  typedef enum logic [3:0] {
    IDLE, ST_RD, WR_SET, WR_PULSE, WR_HOLD, WR_TBRE, WR_TSRE,
    RD_WAIT, RD_PULSE, RD_END, DONE
  } state_e;

  state_e               state, state_n;
  logic [CNT_W-1:0]     pulse_cnt, pulse_cnt_n;
  logic [DATA_W-1:0]    data_out_n;
  logic [RDATA_W-1:0]   rdata_n;
  logic                 ack_n, bus_own_n, data_oe_n, wrn_n, rdn_n;

`ifdef UART_BUS_RESPONDER_TIMEOUT_EN
  logic [WAIT_W-1:0]    wait_cnt, wait_cnt_n;
  logic                 err_q, err_n;
  logic                 in_wait;
`endif

  // Next-state and next-output logic; every output is registered from state_n.
  always_comb begin
    state_n     = state;
    pulse_cnt_n = pulse_cnt;
    data_out_n  = uco_data_out;
    rdata_n     = uco_rdata;
`ifdef UART_BUS_RESPONDER_TIMEOUT_EN
    err_n       = err_q;
    wait_cnt_n  = '0;
    in_wait     = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (uci_req) begin
          if (uci_sel) begin
            state_n = ST_RD;
          end else if (uci_we) begin
            state_n    = WR_SET;
            data_out_n = uci_wdata;
          end else begin
            state_n = RD_WAIT;
          end
        end
      end
      ST_RD: begin
        rdata_n = {14'd0, uci_data_ready, uci_tbre & uci_tsre};
        state_n = DONE;
      end
      WR_SET: begin
        state_n     = WR_PULSE;
        pulse_cnt_n = '0;
      end
      WR_PULSE: begin
        if (pulse_cnt == CNT_W'(WR_PULSE_CYC - 1)) state_n = WR_HOLD;
        else pulse_cnt_n = pulse_cnt + CNT_W'(1);
      end
      WR_HOLD: state_n = WR_TBRE;
      // Skip the shift-register wait when both flags are already up.
      WR_TBRE: begin
        if (uci_tbre) state_n = uci_tsre ? DONE : WR_TSRE;
      end
      WR_TSRE: begin
        if (uci_tsre) state_n = DONE;
      end
      RD_WAIT: begin
        if (uci_data_ready) begin
          state_n     = RD_PULSE;
          pulse_cnt_n = '0;
        end
      end
      RD_PULSE: begin
        if (pulse_cnt == CNT_W'(RD_PULSE_CYC - 1)) begin
          rdata_n = {8'd0, uci_data_in};
          state_n = RD_END;
        end else begin
          pulse_cnt_n = pulse_cnt + CNT_W'(1);
        end
      end
      RD_END:  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

`ifdef UART_BUS_RESPONDER_TIMEOUT_EN
    // Bound every wait state; the counter restarts whenever the state changes.
    if (state == IDLE && uci_req) err_n = 1'b0;
    in_wait = (state == WR_TBRE) || (state == WR_TSRE) || (state == RD_WAIT);
    if (in_wait && state_n == state && wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
      state_n = DONE;
      err_n   = 1'b1;
      rdata_n = '1;
    end
    if (in_wait && state_n == state) wait_cnt_n = wait_cnt + WAIT_W'(1);
`endif

    ack_n     = (state_n == DONE);
    bus_own_n = (state_n != IDLE);
    data_oe_n = (state_n == WR_SET) || (state_n == WR_PULSE) || (state_n == WR_HOLD);
    wrn_n     = (state_n != WR_PULSE);
    rdn_n     = (state_n != RD_PULSE);
  end

  always_ff @(posedge uci_clk or negedge uci_rst) begin
    if (!uci_rst) begin
      state        <= IDLE;
      pulse_cnt    <= '0;
      uco_ack      <= 1'b0;
      uco_rdata    <= '0;
      uco_bus_own  <= 1'b0;
      uco_data_oe  <= 1'b0;
      uco_data_out <= '0;
      uco_wrn      <= 1'b1;
      uco_rdn      <= 1'b1;
    end else begin
      state        <= state_n;
      pulse_cnt    <= pulse_cnt_n;
      uco_ack      <= ack_n;
      uco_rdata    <= rdata_n;
      uco_bus_own  <= bus_own_n;
      uco_data_oe  <= data_oe_n;
      uco_data_out <= data_out_n;
      uco_wrn      <= wrn_n;
      uco_rdn      <= rdn_n;
    end
  end

`ifdef UART_BUS_RESPONDER_TIMEOUT_EN
  always_ff @(posedge uci_clk or negedge uci_rst) begin
    if (!uci_rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_n;
      err_q    <= err_n;
    end
  end

  assign uco_err = err_q;
`else
  assign uco_err = 1'b0;
`endif

  // The pipeline advances on the ack cycle itself.
  assign uco_stall = (uci_req | uco_bus_own) & ~uco_ack;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Self-checking bench for uart_bus_responder: timeline model plus directed transactions.
// Optional timeout case runs when UART_BUS_RESPONDER_TIMEOUT_EN is defined.
module tb_uart_bus_responder;

  localparam int WRP = 2;
  localparam int RDP = 2;
  localparam int TO  = 16;
`ifdef UART_BUS_RESPONDER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk, rst_n, req, we, sel, tbre, tsre, data_ready;
  logic [7:0] wdata, data_in, data_out;
  logic ack, stall, err, bus_own, data_oe, wrn, rdn;
  logic [15:0] rdata;

  int n_chk, n_fail;

  uart_bus_responder #(.WR_PULSE_CYC(WRP), .RD_PULSE_CYC(RDP), .TIMEOUT_CYC(TO)) dut (
    .uci_clk(clk), .uci_rst(rst_n), .uci_req(req), .uci_we(we), .uci_sel(sel),
    .uci_wdata(wdata), .uco_ack(ack), .uco_rdata(rdata), .uco_stall(stall),
    .uco_err(err), .uco_bus_own(bus_own), .uco_data_oe(data_oe), .uco_data_out(data_out),
    .uci_data_in(data_in), .uco_wrn(wrn), .uco_rdn(rdn), .uci_tbre(tbre),
    .uci_tsre(tsre), .uci_data_ready(data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: an operation is a timeline of cycles counted from acceptance (cycle 1).
  typedef enum logic [1:0] {OP_NONE, OP_STAT, OP_WR, OP_RD} op_e;
  op_e         m_op;
  int          m_t, m_rs, m_wt;
  logic        m_got, m_done, m_err;
  logic [15:0] m_rdata;
  logic [7:0]  m_wdata;

  function automatic logic to_hit(input int wt);
    return TO_EN && (wt == TO - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_op <= OP_NONE; m_t <= 0; m_rs <= 0; m_wt <= 0;
      m_got <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_rdata <= '0; m_wdata <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_op   <= OP_NONE;
    end else if (m_op == OP_NONE) begin
      if (req) begin
        m_t <= 1; m_rs <= 0; m_wt <= 0; m_got <= 1'b0; m_err <= 1'b0;
        if (sel) m_op <= OP_STAT;
        else if (we) begin m_op <= OP_WR; m_wdata <= wdata; end
        else m_op <= OP_RD;
      end
    end else begin
      m_t <= m_t + 1;
      if (m_op == OP_STAT) begin
        m_rdata <= {14'd0, data_ready, tbre & tsre};
        m_done  <= 1'b1;
      end else if (m_op == OP_WR && m_t >= WRP + 3) begin
        if (tsre && (m_got || tbre)) m_done <= 1'b1;
        else if (!m_got && tbre) begin m_got <= 1'b1; m_wt <= 0; end
        else if (to_hit(m_wt)) begin m_done <= 1'b1; m_err <= 1'b1; m_rdata <= 16'hFFFF; end
        else m_wt <= m_wt + 1;
      end else if (m_op == OP_RD) begin
        if (m_rs == 0) begin
          if (data_ready) m_rs <= m_t + 1;
          else if (to_hit(m_wt)) begin m_done <= 1'b1; m_err <= 1'b1; m_rdata <= 16'hFFFF; end
          else m_wt <= m_wt + 1;
        end else begin
          if (m_t == m_rs + RDP - 1) m_rdata <= {8'd0, data_in};
          if (m_t == m_rs + RDP) m_done <= 1'b1;
        end
      end
    end
  end

  logic exp_own, exp_ack, exp_oe, exp_wrn, exp_rdn, exp_stall, wr_act;
  assign exp_own   = (m_op != OP_NONE);
  assign exp_ack   = m_done;
  assign wr_act    = (m_op == OP_WR) && !m_done;
  assign exp_oe    = wr_act && (m_t <= WRP + 2);
  assign exp_wrn   = !(wr_act && m_t >= 2 && m_t <= WRP + 1);
  assign exp_rdn   = !((m_op == OP_RD) && !m_done && m_rs != 0 && m_t >= m_rs && m_t < m_rs + RDP);
  assign exp_stall = (req | exp_own) & !m_done;

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ack",     32'(ack),     32'(exp_ack));
      check("bus_own", 32'(bus_own), 32'(exp_own));
      check("data_oe", 32'(data_oe), 32'(exp_oe));
      check("wrn",     32'(wrn),     32'(exp_wrn));
      check("rdn",     32'(rdn),     32'(exp_rdn));
      check("stall",   32'(stall),   32'(exp_stall));
      check("rdata",   32'(rdata),   32'(m_rdata));
      check("err",     32'(err),     32'(m_err));
      if (exp_oe) check("data_out", 32'(data_out), 32'(m_wdata));
      check("oe_rdn_excl", 32'(data_oe & ~rdn), 32'(0));
    end
  end

  // One request; inputs change 2 units after a posedge, observations at negedge.
  task automatic txn(input logic w, input logic s, input logic [7:0] d,
                     input int tbre_at, input int dr_at, input int drop_at,
                     output int lat, output int wrn_lo, output int rdn_lo,
                     output int oe_cnt, output int byte_ok,
                     output logic [15:0] rd, output logic er);
    lat = -1; wrn_lo = 0; rdn_lo = 0; oe_cnt = 0; byte_ok = 0; rd = '0; er = 1'b0;
    @(posedge clk); #2;
    req = 1'b1; we = w; sel = s; wdata = d;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #2;
      if (i == tbre_at) tbre = 1'b1;
      if (i == dr_at) data_ready = 1'b1;
      if (i == drop_at) req = 1'b0;
      @(negedge clk);
      if (!wrn) wrn_lo++;
      if (!rdn) rdn_lo++;
      if (data_oe) oe_cnt++;
      if (data_oe && data_out == d) byte_ok++;
      if (ack) begin lat = i; rd = rdata; er = err; break; end
    end
    #1 req = 1'b0; we = 1'b0; sel = 1'b0;
    if (lat < 0) check("ack_wait_bound", 32'(lat), 32'(0));
  endtask

  int lat, wlo, rlo, oec, bok;
  logic [15:0] rd;
  logic er;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; sel = 1'b0; wdata = '0;
    data_in = 8'h5A; tbre = 1'b1; tsre = 1'b1; data_ready = 1'b0;
    #12;
    check("rst_wrn", 32'(wrn), 32'(1));
    check("rst_rdn", 32'(rdn), 32'(1));
    check("rst_oe", 32'(data_oe), 32'(0));
    check("rst_own", 32'(bus_own), 32'(0));
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    check("rst_data_out", 32'(data_out), 32'(0));
    #1 rst_n = 1'b1;

    // Write 0x41 with transmitter idle.
    txn(1'b1, 1'b0, 8'h41, 0, 0, 0, lat, wlo, rlo, oec, bok, rd, er);
    check("wr41_latency", 32'(lat), 32'(6));
    check("wr41_wrn_low", 32'(wlo), 32'(2));
    check("wr41_oe_cycles", 32'(oec), 32'(4));
    check("wr41_bus_byte", 32'(bok), 32'(4));

    // Write with tbre arriving 10 clocks late.
    tbre = 1'b0;
    txn(1'b1, 1'b0, 8'h3C, 10, 0, 0, lat, wlo, rlo, oec, bok, rd, er);
    check("wr_tbre_latency", 32'(lat), 32'(11));
    check("wr_tbre_wrn_low", 32'(wlo), 32'(2));

    // Data read, byte arrives after 5 clocks.
    txn(1'b0, 1'b0, 8'h00, 0, 5, 0, lat, wlo, rlo, oec, bok, rd, er);
    data_ready = 1'b0;
    check("rd_latency", 32'(lat), 32'(9));
    check("rd_rdn_low", 32'(rlo), 32'(2));
    check("rd_oe_cycles", 32'(oec), 32'(0));
    check("rd_rdata", 32'(rd), 32'(16'h005A));

    // Status reads.
    txn(1'b0, 1'b1, 8'h00, 0, 0, 0, lat, wlo, rlo, oec, bok, rd, er);
    check("st_latency", 32'(lat), 32'(2));
    check("st_tx_ready", 32'(rd), 32'(16'h0001));
    data_ready = 1'b1; tsre = 1'b0;
    txn(1'b0, 1'b1, 8'h00, 0, 0, 0, lat, wlo, rlo, oec, bok, rd, er);
    check("st_rx_ready", 32'(rd), 32'(16'h0002));
    data_ready = 1'b0; tsre = 1'b1;

    // Write to the status address behaves as a status read.
    txn(1'b1, 1'b1, 8'h99, 0, 0, 0, lat, wlo, rlo, oec, bok, rd, er);
    check("wsel_latency", 32'(lat), 32'(2));
    check("wsel_wrn_low", 32'(wlo), 32'(0));
    check("wsel_rdata", 32'(rd), 32'(16'h0001));

    // Request dropped mid-write still completes.
    txn(1'b1, 1'b0, 8'hA5, 0, 0, 2, lat, wlo, rlo, oec, bok, rd, er);
    check("drop_latency", 32'(lat), 32'(6));
    check("drop_wrn_low", 32'(wlo), 32'(2));

    // Asynchronous reset in the middle of the write pulse.
    @(posedge clk); #2;
    req = 1'b1; we = 1'b1; sel = 1'b0; wdata = 8'h77;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_wrn_low", 32'(wrn), 32'(0));
    #1 rst_n = 1'b0; req = 1'b0; we = 1'b0;
    #1;
    check("mid_rst_wrn", 32'(wrn), 32'(1));
    check("mid_rst_oe", 32'(data_oe), 32'(0));
    check("mid_rst_own", 32'(bus_own), 32'(0));
    #17 rst_n = 1'b1;
    txn(1'b0, 1'b1, 8'h00, 0, 0, 0, lat, wlo, rlo, oec, bok, rd, er);
    check("post_rst_latency", 32'(lat), 32'(2));
    check("post_rst_rdata", 32'(rd), 32'(16'h0001));

`ifdef UART_BUS_RESPONDER_TIMEOUT_EN
    // Read with no byte ever arriving ends in a timeout.
    txn(1'b0, 1'b0, 8'h00, 0, 0, 0, lat, wlo, rlo, oec, bok, rd, er);
    check("to_latency", 32'(lat), 32'(TO + 1));
    check("to_err", 32'(er), 32'(1));
    check("to_rdata", 32'(rd), 32'(16'hFFFF));
    check("to_rdn_low", 32'(rlo), 32'(0));
    txn(1'b0, 1'b1, 8'h00, 0, 0, 0, lat, wlo, rlo, oec, bok, rd, er);
    check("to_err_cleared", 32'(er), 32'(0));
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
